// File: rtl/morse_char_queue_if.sv
// rtl/morse_char_queue_if.sv - decoder/driver side signals of the Morse character queue
interface morse_char_queue_if #(
    parameter int DEPTH = 8,
    parameter int COLS  = 16
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int COL_W = $clog2(COLS + 1);

    logic             en;
    logic [7:0]       char_in;
    logic             char_stb;
    logic             char_ok;
    logic             drv_ready;
    logic [7:0]       char_out;
    logic             write_out;
    logic             is_cmd;
    logic [CNT_W-1:0] count;
    logic             full;
    logic             empty;
    logic             overflow;
    logic             cur_row;
    logic [COL_W-1:0] cur_col;

    modport slave (
        input  en, char_in, char_stb, char_ok, drv_ready,
        output char_out, write_out, is_cmd, count, full, empty, overflow, cur_row, cur_col
    );

    modport master (
        output en, char_in, char_stb, char_ok, drv_ready,
        input  char_out, write_out, is_cmd, count, full, empty, overflow, cur_row, cur_col
    );
endinterface

// File: rtl/morse_char_queue.sv
// rtl/morse_char_queue.sv - character FIFO with LCD cursor tracking and serialized write issue
module morse_char_queue #(
    parameter int         DEPTH     = 8,
    parameter int         COLS      = 16,
    parameter logic [7:0] CMD_ROW1  = 8'hC0,
    parameter logic [7:0] CMD_CLEAR = 8'h01
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    morse_char_queue_if.slave    q_if
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int COL_W = $clog2(COLS + 1);
    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t           r_state;
    logic [7:0]       r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;
    logic [7:0]       r_char_out;
    logic             r_write_out;
    logic             r_is_cmd;
    logic             r_cur_row;
    logic [COL_W-1:0] r_cur_col;

    logic w_empty, w_full, w_push_req, w_idle_go, w_at_end;
    logic w_wrap, w_pop, w_bypass, w_store, w_lost;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_W'(DEPTH));
    assign w_push_req = q_if.char_stb & q_if.char_ok & q_if.en;
    assign w_idle_go  = q_if.en & q_if.drv_ready & (r_state == S_IDLE);
    assign w_at_end   = (r_cur_col == COL_W'(COLS));

    // Wrap commands wait for a pending character; an empty queue lets a fresh
    // push go straight to the driver without occupying a FIFO slot.
    assign w_wrap   = w_idle_go & w_at_end & ~w_empty;
    assign w_pop    = w_idle_go & ~w_at_end & ~w_empty;
    assign w_bypass = w_idle_go & ~w_at_end & w_empty & w_push_req;
    assign w_store  = w_push_req & ~w_bypass & (~w_full | w_pop);
    assign w_lost   = w_push_req & w_full & ~w_pop;

    always_ff @(posedge i_clk) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= q_if.char_in;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_count     <= '0;
            r_overflow  <= 1'b0;
            r_char_out  <= 8'h00;
            r_write_out <= 1'b0;
            r_is_cmd    <= 1'b0;
            r_cur_row   <= 1'b0;
            r_cur_col   <= '0;
        end else begin
            r_write_out <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_wrap) begin
                        r_write_out <= 1'b1;
                        r_is_cmd    <= 1'b1;
                        r_char_out  <= r_cur_row ? CMD_CLEAR : CMD_ROW1;
                        r_state     <= S_WAIT_BUSY;
                    end else if (w_pop || w_bypass) begin
                        r_write_out <= 1'b1;
                        r_is_cmd    <= 1'b0;
                        r_char_out  <= w_pop ? r_mem[r_rd_ptr] : q_if.char_in;
                        r_state     <= S_WAIT_BUSY;
                    end
                end
                S_WAIT_BUSY: if (!q_if.drv_ready) r_state <= S_WAIT_DONE;
                S_WAIT_DONE: if (q_if.drv_ready)  r_state <= S_IDLE;
                default:     r_state <= S_IDLE;
            endcase

            // Disable flushes state but leaves an in-flight driver handshake alone.
            if (!q_if.en) begin
                r_wr_ptr   <= '0;
                r_rd_ptr   <= '0;
                r_count    <= '0;
                r_overflow <= 1'b0;
                r_cur_row  <= 1'b0;
                r_cur_col  <= '0;
            end else begin
                if (w_store) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                if (w_pop)   r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_count <= r_count + CNT_W'(w_store) - CNT_W'(w_pop);
                if (w_lost)  r_overflow <= 1'b1;
                if (w_wrap) begin
                    r_cur_row <= ~r_cur_row;
                    r_cur_col <= '0;
                end else if (w_pop || w_bypass) begin
                    r_cur_col <= r_cur_col + COL_W'(1);
                end
            end
        end
    end

    assign q_if.char_out  = r_char_out;
    assign q_if.write_out = r_write_out;
    assign q_if.is_cmd    = r_is_cmd;
    assign q_if.count     = r_count;
    assign q_if.full      = w_full;
    assign q_if.empty     = w_empty;
    assign q_if.overflow  = r_overflow;
    assign q_if.cur_row   = r_cur_row;
    assign q_if.cur_col   = r_cur_col;
endmodule

// File: tb/tb_morse_char_queue.sv
// tb/tb_morse_char_queue.sv - directed vector bench for morse_char_queue
module tb_morse_char_queue;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    morse_char_queue_if #(.DEPTH(8), .COLS(16)) bus ();

    morse_char_queue #(.DEPTH(8), .COLS(16), .CMD_ROW1(8'hC0), .CMD_CLEAR(8'h01)) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .q_if    (bus)
    );

    int n_chk = 0;
    int n_err = 0;

    logic drv_auto = 1'b0;
    logic man_rdy;
    logic model_rdy = 1'b1;
    int   busy_cnt = 0;
    assign bus.drv_ready = drv_auto ? model_rdy : man_rdy;

    // Driver model: drops ready for 5 cycles after every write strobe
    always @(negedge clk) begin
        if (!drv_auto) begin
            model_rdy = 1'b1;
            busy_cnt  = 0;
        end else if (bus.write_out) begin
            model_rdy = 1'b0;
            busy_cnt  = 5;
        end else if (busy_cnt > 0) begin
            busy_cnt = busy_cnt - 1;
            if (busy_cnt == 0) model_rdy = 1'b1;
        end
    end

    logic [8:0] log_q[$];
    always @(negedge clk) begin
        if (bus.write_out) log_q.push_back({bus.is_cmd, bus.char_out});
    end

    typedef struct {
        logic       en;
        logic       stb;
        logic       ok;
        logic [7:0] ch;
        logic       rdy;
        logic       wr;
        logic [7:0] cout;
        logic       cmd;
        int         cnt;
        logic       ovf;
        int         col;
    } vec_t;

    vec_t vt[9];

    task automatic check(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] c);
        bus.char_stb = 1'b1;
        bus.char_ok  = 1'b1;
        bus.char_in  = c;
        tick();
        bus.char_stb = 1'b0;
    endtask

    task automatic wait_writes(input int n, input int limit, input string nm);
        int k = 0;
        while (log_q.size() < n && k < limit) begin
            tick();
            k++;
        end
        check(nm, log_q.size(), n);
    endtask

    logic [8:0] exp_q[$];

    initial begin
        vt[0] = '{1'b1, 1'b1, 1'b1, 8'h45, 1'b1, 1'b1, 8'h45, 1'b0, 0, 1'b0, 1};
        vt[1] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h45, 1'b0, 0, 1'b0, 1};
        vt[2] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h45, 1'b0, 0, 1'b0, 1};
        vt[3] = '{1'b1, 1'b1, 1'b0, 8'h3F, 1'b0, 1'b0, 8'h45, 1'b0, 0, 1'b0, 1};
        vt[4] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h45, 1'b0, 0, 1'b0, 1};
        vt[5] = '{1'b1, 1'b1, 1'b0, 8'h3F, 1'b1, 1'b0, 8'h45, 1'b0, 0, 1'b0, 1};
        vt[6] = '{1'b1, 1'b1, 1'b1, 8'h51, 1'b0, 1'b0, 8'h45, 1'b0, 1, 1'b0, 1};
        vt[7] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'h51, 1'b0, 0, 1'b0, 2};
        vt[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h51, 1'b0, 0, 1'b0, 0};

        rst_n        = 1'b0;
        bus.en       = 1'b1;
        bus.char_in  = 8'h00;
        bus.char_stb = 1'b0;
        bus.char_ok  = 1'b0;
        man_rdy      = 1'b1;
        tick();
        tick();
        check("rst_count", bus.count, 0);
        check("rst_empty", bus.empty, 1);
        check("rst_full", bus.full, 0);
        check("rst_ovf", bus.overflow, 0);
        check("rst_char", bus.char_out, 8'h00);
        check("rst_write", bus.write_out, 0);
        check("rst_cmd", bus.is_cmd, 0);
        check("rst_row", bus.cur_row, 0);
        check("rst_col", bus.cur_col, 0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 9; i++) begin
            bus.en       = vt[i].en;
            bus.char_stb = vt[i].stb;
            bus.char_ok  = vt[i].ok;
            bus.char_in  = vt[i].ch;
            man_rdy      = vt[i].rdy;
            tick();
            check($sformatf("vec%0d_write", i), bus.write_out, vt[i].wr);
            check($sformatf("vec%0d_char", i), bus.char_out, vt[i].cout);
            check($sformatf("vec%0d_cmd", i), bus.is_cmd, vt[i].cmd);
            check($sformatf("vec%0d_count", i), bus.count, vt[i].cnt);
            check($sformatf("vec%0d_empty", i), bus.empty, vt[i].cnt == 0);
            check($sformatf("vec%0d_ovf", i), bus.overflow, vt[i].ovf);
            check($sformatf("vec%0d_col", i), bus.cur_col, vt[i].col);
        end
        bus.char_stb = 1'b0;
        bus.char_ok  = 1'b0;
        bus.en       = 1'b1;

        // Overflow: ten pushes while the driver is stalled
        man_rdy = 1'b0;
        tick();
        for (int i = 0; i < 10; i++) push(8'h41 + 8'(i));
        check("ovf_count", bus.count, 8);
        check("ovf_full", bus.full, 1);
        check("ovf_flag", bus.overflow, 1);
        log_q.delete();
        drv_auto = 1'b1;
        wait_writes(8, 200, "ovf_drain_timeout");
        repeat (60) tick();
        check("ovf_total_writes", log_q.size(), 8);
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            check($sformatf("ovf_seq%0d", i), log_q[i], {1'b0, 8'h41 + 8'(i)});
        check("ovf_col", bus.cur_col, 8);
        check("ovf_empty", bus.empty, 1);

        // Row change and clear-on-wrap across 33 characters
        bus.en = 1'b0;
        tick();
        bus.en = 1'b1;
        check("home_col", bus.cur_col, 0);
        check("home_ovf", bus.overflow, 0);
        log_q.delete();
        exp_q.delete();
        for (int i = 1; i <= 33; i++) begin
            if (i == 17) exp_q.push_back({1'b1, 8'hC0});
            if (i == 33) exp_q.push_back({1'b1, 8'h01});
            exp_q.push_back({1'b0, 8'h40 + 8'(i)});
        end
        for (int i = 1; i <= 33; i++) begin
            push(8'h40 + 8'(i));
            repeat (9) tick();
        end
        wait_writes(35, 600, "wrap_timeout");
        repeat (10) tick();
        check("wrap_total_writes", log_q.size(), 35);
        for (int i = 0; i < 35 && i < log_q.size(); i++)
            check($sformatf("wrap_seq%0d", i), log_q[i], exp_q[i]);
        check("wrap_row", bus.cur_row, 0);
        check("wrap_col", bus.cur_col, 1);
        check("wrap_ovf", bus.overflow, 0);

        // Push while full in the same cycle as a pop
        man_rdy  = 1'b0;
        drv_auto = 1'b0;
        tick();
        for (int i = 0; i < 8; i++) push(8'h30 + 8'(i));
        check("fp_full_before", bus.full, 1);
        bus.char_stb = 1'b1;
        bus.char_ok  = 1'b1;
        bus.char_in  = 8'h38;
        man_rdy      = 1'b1;
        tick();
        bus.char_stb = 1'b0;
        check("fp_write", bus.write_out, 1);
        check("fp_char", bus.char_out, 8'h30);
        check("fp_count", bus.count, 8);
        check("fp_ovf", bus.overflow, 0);
        man_rdy = 1'b0;
        tick();
        log_q.delete();
        drv_auto = 1'b1;
        wait_writes(8, 200, "fp_drain_timeout");
        for (int i = 0; i < 8 && i < log_q.size(); i++)
            check($sformatf("fp_seq%0d", i), log_q[i], {1'b0, 8'h31 + 8'(i)});
        repeat (10) tick();

        // EN dropped while the driver handshake is in WAIT_DONE
        drv_auto = 1'b0;
        man_rdy  = 1'b0;
        tick();
        for (int i = 0; i < 6; i++) push(8'h61 + 8'(i));
        man_rdy = 1'b1;
        tick();
        check("en_issue", bus.write_out, 1);
        man_rdy = 1'b0;
        tick();
        check("en_count_before", bus.count, 5);
        bus.en = 1'b0;
        tick();
        check("en_count", bus.count, 0);
        check("en_col", bus.cur_col, 0);
        check("en_empty", bus.empty, 1);
        log_q.delete();
        repeat (3) tick();
        man_rdy = 1'b1;
        repeat (2) tick();
        bus.en = 1'b1;
        repeat (10) tick();
        check("en_no_write", log_q.size(), 0);
        push(8'h5A);
        check("en_new_write", bus.write_out, 1);
        check("en_new_char", bus.char_out, 8'h5A);
        check("en_new_cmd", bus.is_cmd, 0);
        check("en_new_col", bus.cur_col, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/morse_char_queue.md
Name: morse_char_queue

Overview:
- Buffers decoded ASCII characters between the Morse-to-character decoder and the LCD driver FSM.
- The decoder emits single-cycle character strobes. The LCD driver can accept only one write per busy/ready cycle.
- The block queues characters, discards invalid ones, and tracks the cursor on a 2-row display.
- It inserts the LCD commands for row change and clear-on-wrap, so the driver only ever sees a serialized WRITE stream.

Parameters:
- DEPTH, 8, number of FIFO entries; power of two, minimum 2.
- COLS, 16, characters per LCD row.
- CMD_ROW1, 8'hC0, command that sets DDRAM address to the start of row 1.
- CMD_CLEAR, 8'h01, command that clears the display and homes the cursor.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous reset, active-low.
- EN  in  1  enable. Low flushes the queue and homes the cursor.
- CHAR_IN  in  8  ASCII character from the decoder.
- CHAR_STB  in  1  one-cycle strobe; CHAR_IN is valid on this cycle.
- CHAR_OK  in  1  decoder valid flag, sampled with CHAR_STB.
- DRV_READY  in  1  high when the LCD driver is idle and can take a write.
- CHAR_OUT  out  8  byte presented to the driver.
- WRITE_OUT  out  1  one-cycle write strobe to the driver.
- IS_CMD  out  1  1 = CHAR_OUT is a command (RS=0), 0 = data.
- COUNT  out  $clog2(DEPTH+1)  current FIFO occupancy.
- FULL  out  1  COUNT == DEPTH.
- EMPTY  out  1  COUNT == 0.
- OVERFLOW  out  1  sticky; set when a valid character is lost.
- CUR_ROW  out  1  current cursor row.
- CUR_COL  out  $clog2(COLS+1)  current cursor column, range 0..COLS.

Behaviour:
- Reset values (RST_N low, asynchronous):
  - COUNT=0, EMPTY=1, FULL=0, OVERFLOW=0.
  - CHAR_OUT=8'h00, WRITE_OUT=0, IS_CMD=0.
  - CUR_ROW=0, CUR_COL=0, FSM=IDLE.
- Push rules:
  - A push happens on a CHAR_STB cycle with CHAR_OK=1 and EN=1.
  - CHAR_STB with CHAR_OK=0 is ignored: no push, no flag.
  - Push while FULL with no pop in the same cycle: the character is dropped and OVERFLOW is set.
  - Push and pop in the same cycle (including while FULL): both occur and COUNT is unchanged.
- FIFO pointers wrap modulo DEPTH. Data is popped in push order.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
- IDLE issues a write only when EN=1, DRV_READY=1, and one of these conditions holds:
  - CUR_COL==COLS and CUR_ROW==0: emit CMD_ROW1 with IS_CMD=1. Set CUR_ROW=1, CUR_COL=0. No pop.
  - CUR_COL==COLS and CUR_ROW==1: emit CMD_CLEAR with IS_CMD=1. Set CUR_ROW=0, CUR_COL=0. No pop.
  - Otherwise, if EMPTY=0: pop the head, emit it with IS_CMD=0, and increment CUR_COL.
  - Wrap commands are issued only when a character is pending (EMPTY=0). An idle full row is left untouched.
- Issue timing: WRITE_OUT is high for exactly the issue cycle. CHAR_OUT and IS_CMD are registered and held until the next issue. The next state is WAIT_BUSY.
- WAIT_BUSY: stays until DRV_READY=0, then goes to WAIT_DONE.
- WAIT_DONE: stays until DRV_READY=1, then goes to IDLE.
- Minimum spacing between WRITE_OUT pulses is 3 cycles.
- Latency: a character pushed into an empty queue while IDLE, with DRV_READY=1 and no pending wrap, appears on WRITE_OUT in the cycle after CHAR_STB.
- EN low (synchronous, takes effect every cycle it is low):
  - Clears the FIFO (COUNT=0), OVERFLOW, CUR_ROW and CUR_COL.
  - Blocks new issues.
  - A transaction already in WAIT_BUSY or WAIT_DONE runs to completion, so the driver handshake is never abandoned.
- Reset mid-transaction returns to IDLE immediately. The driver is expected to share the same reset.

Test Plan:
- Push 'E' (8'h45) with CHAR_OK=1 and DRV_READY=1 -> the next cycle shows WRITE_OUT=1, CHAR_OUT=8'h45, IS_CMD=0, CUR_COL=1, COUNT=0.
- Hold DRV_READY=0 and push 10 valid characters 'A'..'J' -> COUNT=8, FULL=1, OVERFLOW=1. Release DRV_READY with a driver model that pulses busy 5 cycles per write -> output sequence 'A'..'H' in order; 'I' and 'J' never appear.
- CHAR_STB with CHAR_OK=0 and CHAR_IN=8'h3F -> COUNT unchanged, no WRITE_OUT, OVERFLOW stays 0.
- Stream 17 characters -> 16 data writes, then CHAR_OUT=8'hC0 with IS_CMD=1, then character 17 as data. After 33 characters a write of 8'h01 with IS_CMD=1 precedes character 33, and CUR_ROW=0, CUR_COL=1 after it.
- With FULL=1 and a pop issuing in the same cycle as CHAR_STB -> COUNT stays 8, no OVERFLOW, and the new character is delivered last.
- Drop EN during WAIT_DONE with COUNT=5 -> COUNT=0 and CUR_COL=0 the next cycle. The FSM returns to IDLE only after DRV_READY rises, and no WRITE_OUT occurs afterward until a new push with EN=1.
